// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game-flow blocks (level controller, frog, display).
//   game_state_t  : game state encoding, as seen on o_State
//   SCORE_W       : score/level width
//   LIVES_W       : lives counter width
//   MAX_LIVES     : upper bound on the lives counter
//   LFSR_W        : width of the reverse-pattern LFSR
//   lfsr_next()   : one step of the x^8+x^6+x^5+x^4+1 Fibonacci LFSR
//   is_mult_of_5(): bonus-life score test
// -----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAY      = 2'd1,
        ST_LEVEL_UP  = 2'd2,
        ST_GAME_OVER = 2'd3
    } game_state_t;

    localparam int SCORE_W = 6;
    localparam int LIVES_W = 2;
    localparam logic [LIVES_W-1:0] MAX_LIVES = 2'd3;
    localparam int LFSR_W  = 8;

    // Taps 8,6,5,4 (1-based) map to bits 7,5,4,3; new bit shifts in at the LSB.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

    function automatic logic is_mult_of_5(input logic [SCORE_W-1:0] score);
        return ((score % 6'd5) == 6'd0);
    endfunction

endpackage

// File: rtl/reverse_pattern_lfsr.sv
// -----------------------------------------------------------------------------
// reverse_pattern_lfsr
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) supplying the pseudo-
// random lane direction mask. Advances on every clock, never stalls.
// Ports:
//   i_Clk    in  1  clock, posedge
//   i_Rst_n  in  1  asynchronous active-low reset, loads SEED
//   o_Lfsr   out 8  current LFSR state (registered)
// SEED must be nonzero, otherwise the register locks up at zero.
// -----------------------------------------------------------------------------
module reverse_pattern_lfsr
    import game_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    output logic [LFSR_W-1:0] o_Lfsr
);

    logic [LFSR_W-1:0] lfsr_r;

    // LFSR state register, stepped every cycle
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            lfsr_r <= SEED;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    assign o_Lfsr = lfsr_r;

endmodule

// File: rtl/level_controller.sv
// -----------------------------------------------------------------------------
// level_controller
// Game-flow controller upstream of the obstacle-movement stage. Converts frog
// events into score, level-up pulse and lane reverse mask, and tracks lives,
// game state and frog respawn requests.
// Ports:
//   i_Clk         in  1         clock, posedge
//   i_Rst_n       in  1         asynchronous active-low reset
//   i_Start       in  1         start pulse (IDLE / GAME_OVER only)
//   i_Frog_Goal   in  1         frog reached top row
//   i_Collision   in  1         frog hit a car
//   o_Score       out 6         score / level
//   o_Level_Up    out 1         one-cycle pulse, o_Reverse valid alongside
//   o_Reverse     out NUM_BITS  lane direction mask, 1 = right-to-left
//   o_Lives       out 2         remaining lives
//   o_State       out 2         IDLE=0, PLAY=1, LEVEL_UP=2, GAME_OVER=3
//   o_Frog_Reset  out 1         one-cycle respawn request
// Build option: LEVEL_CTRL_BONUS_LIFE_EN - when defined, a level-up whose new
// score is a multiple of 5 adds one life (capped at MAX_LIVES).
// -----------------------------------------------------------------------------
module level_controller
    import game_pkg::*;
#(
    parameter int                NUM_BITS    = 4,
    parameter int                START_LIVES = 3,
    parameter int                MAX_SCORE   = 63,
    parameter int                LEVEL_HOLD  = 25000000,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = 8'hA5
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    input  logic                i_Start,
    input  logic                i_Frog_Goal,
    input  logic                i_Collision,
    output logic [SCORE_W-1:0]  o_Score,
    output logic                o_Level_Up,
    output logic [NUM_BITS-1:0] o_Reverse,
    output logic [LIVES_W-1:0]  o_Lives,
    output logic [1:0]          o_State,
    output logic                o_Frog_Reset
);

    localparam int HOLD_W = (LEVEL_HOLD > 1) ? $clog2(LEVEL_HOLD) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(LEVEL_HOLD - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX   = SCORE_W'(MAX_SCORE);
    localparam logic [LIVES_W-1:0] LIVES_START = LIVES_W'(START_LIVES);

    game_state_t         state_r;
    logic [SCORE_W-1:0]  score_r;
    logic                level_up_r;
    logic [NUM_BITS-1:0] reverse_r;
    logic [LIVES_W-1:0]  lives_r;
    logic                frog_reset_r;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic [LFSR_W-1:0]   lfsr_s;
    logic                lfsr_unused_s;
    logic [SCORE_W-1:0]  score_inc_s;

    reverse_pattern_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .o_Lfsr  (lfsr_s)
    );

    // Only the low NUM_BITS of the LFSR reach the lanes.
    assign lfsr_unused_s = ^lfsr_s;

    // Saturating score increment applied on a level-up
    always_comb begin
        score_inc_s = score_r;
        if (score_r >= SCORE_MAX) begin
            score_inc_s = SCORE_MAX;
        end else begin
            score_inc_s = score_r + 6'd1;
        end
    end

    // Game-flow state machine with registered outputs
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_r      <= ST_IDLE;
            score_r      <= 6'd0;
            level_up_r   <= 1'b0;
            reverse_r    <= '0;
            lives_r      <= 2'd0;
            frog_reset_r <= 1'b0;
            hold_cnt_r   <= '0;
        end else begin
            level_up_r   <= 1'b0;
            frog_reset_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_GAME_OVER: begin
                    // Score stays frozen in GAME_OVER until a restart.
                    if (i_Start) begin
                        state_r      <= ST_PLAY;
                        score_r      <= 6'd1;
                        lives_r      <= LIVES_START;
                        reverse_r    <= lfsr_s[NUM_BITS-1:0];
                        level_up_r   <= 1'b1;
                        frog_reset_r <= 1'b1;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_PLAY: begin
                    // Collision takes priority; a coincident goal is dropped.
                    if (i_Collision) begin
                        if (lives_r <= 2'd1) begin
                            lives_r <= 2'd0;
                            state_r <= ST_GAME_OVER;
                        end else begin
                            lives_r      <= lives_r - 2'd1;
                            frog_reset_r <= 1'b1;
                        end
                    end else if (i_Frog_Goal) begin
                        state_r    <= ST_LEVEL_UP;
                        score_r    <= score_inc_s;
                        reverse_r  <= lfsr_s[NUM_BITS-1:0];
                        level_up_r <= 1'b1;
                        hold_cnt_r <= '0;
`ifdef LEVEL_CTRL_BONUS_LIFE_EN
                        if (is_mult_of_5(score_inc_s) && (lives_r < MAX_LIVES)) begin
                            lives_r <= lives_r + 2'd1;
                        end else begin
                            lives_r <= lives_r;
                        end
`endif
                    end else begin
                        state_r <= ST_PLAY;
                    end
                end
                ST_LEVEL_UP: begin
                    // Frog events are ignored while the level banner is held.
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_r      <= ST_PLAY;
                        frog_reset_r <= 1'b1;
                        hold_cnt_r   <= '0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_Score      = score_r;
    assign o_Level_Up   = level_up_r;
    assign o_Reverse    = reverse_r;
    assign o_Lives      = lives_r;
    assign o_State      = state_r;
    assign o_Frog_Reset = frog_reset_r;

endmodule
